// File: rtl/rsa_arbiter.sv
// Round-robin front end sharing one RSA modular-exponentiation core among NREQ requesters.
// Optional RUN-phase watchdog is built only when RSA_ARB_TIMEOUT_EN is defined.
module rsa_arbiter #(
    parameter int WIDTH   = 6,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    parameter int IDW     = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ*6-1:0]       req_key,
    input  logic [NREQ*WIDTH-1:0]   req_n,
    output logic                    core_reset,
    output logic [WIDTH-1:0]        core_data,
    output logic [5:0]              core_key,
    output logic [WIDTH-1:0]        core_n,
    input  logic [WIDTH-1:0]        core_result,
    input  logic                    core_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_result,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_error,
    output logic                    busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("rsa_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [5:0]       key_q, key_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [IDW-1:0]   grant_s;
    logic             grant_vld_s;

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             error_q, error_d;
`endif

    // First valid requester at or after the priority pointer, wrapping modulo NREQ.
    always_comb begin
        int idx;
        grant_s     = '0;
        grant_vld_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!grant_vld_s && req_valid[idx]) begin
                grant_s     = IDW'(idx);
                grant_vld_s = 1'b1;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Accept is offered only while idle and never while reset is held.
    always_comb begin
        if (state_q == ST_IDLE && grant_vld_s && !reset) begin
            req_ready = NREQ'(1) << grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and datapath capture for the four-phase request sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        data_d   = data_q;
        key_d    = key_q;
        n_d      = n_q;
        result_d = result_q;
        valid_d  = valid_q;
`ifdef RSA_ARB_TIMEOUT_EN
        tmo_d    = tmo_q;
        error_d  = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    data_d  = req_data[int'(grant_s)*WIDTH +: WIDTH];
                    key_d   = req_key[int'(grant_s)*6 +: 6];
                    n_d     = req_n[int'(grant_s)*WIDTH +: WIDTH];
                    id_d    = grant_s;
                    ptr_d   = IDW'((int'(grant_s) + 1) % NREQ);
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
`ifdef RSA_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A done in the final allowed cycle takes precedence over the watchdog.
                if (core_done) begin
                    result_d = core_result;
`ifdef RSA_ARB_TIMEOUT_EN
                    error_d  = 1'b0;
`endif
                    valid_d  = 1'b1;
                    state_d  = ST_RESP;
                end
`ifdef RSA_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    tmo_d    = tmo_q + 1'b1;
                end
`else
                else begin
                    state_d = ST_RUN;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            data_q   <= '0;
            key_q    <= 6'd0;
            n_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
            tmo_q    <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            data_q   <= data_d;
            key_q    <= key_d;
            n_q      <= n_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef RSA_ARB_TIMEOUT_EN
            tmo_q    <= tmo_d;
            error_q  <= error_d;
`endif
        end
    end

    assign core_reset = reset | (state_q != ST_RUN);
    assign core_data  = data_q;
    assign core_key   = key_q;
    assign core_n     = n_q;
    assign rsp_valid  = valid_q;
    assign rsp_result = result_q;
    assign rsp_id     = id_q;
    assign busy       = busy_q;
`ifdef RSA_ARB_TIMEOUT_EN
    assign rsp_error  = error_q;
`else
    assign rsp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_arbiter.sv
// Randomized scoreboard bench for rsa_arbiter with a behavioural RSA core model.
module tb_rsa_arbiter;
    localparam int WIDTH = 6;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
`ifdef RSA_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ*6-1:0]     req_key = '0;
    logic [NREQ*WIDTH-1:0] req_n = '0;
    logic                  core_reset;
    logic [WIDTH-1:0]      core_data, core_n, core_result;
    logic [5:0]            core_key;
    logic                  core_done;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [WIDTH-1:0]      rsp_result;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_error;
    logic                  busy;

    rsa_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key), .req_n(req_n),
        .core_reset(core_reset), .core_data(core_data), .core_key(core_key), .core_n(core_n),
        .core_result(core_result), .core_done(core_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_id(rsp_id), .rsp_error(rsp_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int modexp(input int b, input int e, input int m);
        int r;
        if (m == 0) return 0;
        r = 1 % m;
        b = b % m;
        repeat (e) r = (r * b) % m;
        return r;
    endfunction

    // Core model: done arrives lat cycles after leaving reset; garbage result otherwise.
    int  ccnt = 0;
    int  lat = 0;
    bit  no_done = 1'b0;
    bit  spur = 1'b0;
    logic real_done;
    always @(posedge clk) ccnt <= core_reset ? 0 : ccnt + 1;
    assign real_done   = !core_reset && !no_done && (ccnt >= lat);
    assign core_done   = real_done || (spur && core_reset);
    assign core_result = real_done ? WIDTH'(modexp(int'(core_data), int'(core_key), int'(core_n)))
                                   : {WIDTH{1'b1}};

    // Reference model state
    typedef struct { int id; int res; int err; int vcyc; } rsp_t;
    rsp_t exp_q[$];
    bit   out_flag = 1'b0;
    int   ptr = 0;
    int   fixed_lat = -1;
    int   run_lo = 0, run_hi = -1, resp_cyc = 0;
    int   grants = 0;
    int   dut_grants[$];

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g, idx, d, k, n, l;
        bit in_run, tmo_hit;
        rsp_t r;
        if (cyc > 0) begin
            exp_rdy = '0;
            g = -1;
            if (!reset && !out_flag) begin
                for (int i = 0; i < NREQ; i++) begin
                    idx = (ptr + i) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, out_flag);
            in_run = out_flag && cyc >= run_lo && cyc <= run_hi;
            chk("core_reset", core_reset, reset || !in_run);
            if (reset) begin
                out_flag = 1'b0;
                ptr = 0;
                exp_q.delete();
            end else if (g >= 0) begin
                d = int'(req_data[g*WIDTH +: WIDTH]);
                k = int'(req_key[g*6 +: 6]);
                n = int'(req_n[g*WIDTH +: WIDTH]);
                l = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
                lat = l;
                ptr = (g + 1) % NREQ;
                out_flag = 1'b1;
                run_lo = cyc + 2;
                grants++;
`ifdef RSA_ARB_TIMEOUT_EN
                tmo_hit = no_done || (l >= TMO);
`else
                tmo_hit = 1'b0;
`endif
                if (tmo_hit) begin
                    run_hi = run_lo + TMO - 1;
                    r = '{g, 0, 1, run_hi + 1};
                    exp_q.push_back(r);
                end else if (no_done) begin
                    run_hi = 1 << 30;
                end else begin
                    run_hi = run_lo + l;
                    r = '{g, modexp(d, k, n), 0, run_hi + 1};
                    exp_q.push_back(r);
                end
                resp_cyc = run_hi + 1;
            end else if (out_flag && rsp_ready && cyc >= resp_cyc) begin
                out_flag = 1'b0;
            end
        end
    end

    // Observed grant log, used for ordering checks.
    always @(negedge clk) begin
        if (cyc > 0 && !reset) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_grants.push_back(i);
        end
    end

    // Monitor: pops an expectation when a response appears and checks it while held.
    rsp_t cur;
    bit   hold = 1'b0;
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (rsp_valid && !hold) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", rsp_valid, 1'b0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rsp_id", rsp_id, cur.id);
                        chk("rsp_result", rsp_result, cur.res);
                        chk("rsp_error", rsp_error, cur.err);
                        chk("rsp_cycle", cyc, cur.vcyc);
                    end
                end else if (rsp_valid && hold) begin
                    chk("rsp_hold_id", rsp_id, cur.id);
                    chk("rsp_hold_result", rsp_result, cur.res);
                    chk("rsp_hold_error", rsp_error, cur.err);
                end else if (!rsp_valid && hold) begin
                    chk("rsp_dropped", rsp_valid, 1'b1);
                end else if (exp_q.size() > 0 && cyc > exp_q[0].vcyc) begin
                    chk("rsp_missing", rsp_valid, 1'b1);
                    void'(exp_q.pop_front());
                end
                hold = rsp_valid && !rsp_ready;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            req_key[i*6 +: 6]          = 6'($urandom);
            req_n[i*WIDTH +: WIDTH]    = WIDTH'($urandom_range(2, 63));
        end
    endtask

    task automatic wait_grant(input string name);
        int g0 = grants;
        for (int i = 0; i < 100; i++) begin
            step();
            if (grants > g0) return;
        end
        checks++; errors++;
        $display("FAIL wait_grant_%s no grant within budget", name);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (!out_flag && exp_q.size() == 0) return;
            step();
        end
        checks++; errors++;
        $display("FAIL wait_idle_%s busy=%0d pending=%0d", name, busy, exp_q.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rand_ops();
        req_valid = '1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_error", rsp_error, 1'b0);
        chk("rst_core_data", core_data, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_core_n", core_n, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fairness: all requesters pending from reset
        for (int i = 0; i < 200 && grants < 5; i++) step();
        req_valid = '0;
        chk("fair_count", dut_grants.size() >= 5, 1'b1);
        if (dut_grants.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("fair_order", dut_grants[i], i % NREQ);
        end
        wait_idle("fair");

        // Single request: 2^3 mod 5 = 3 from requester 1
        req_data[1*WIDTH +: WIDTH] = 6'd2;
        req_key[1*6 +: 6]          = 6'd3;
        req_n[1*WIDTH +: WIDTH]    = 6'd5;
        fixed_lat = 2;
        req_valid = 4'b0010;
        wait_grant("single");
        req_valid = '0;
        wait_idle("single");

        // Backpressure: response held for 5 cycles with everyone requesting
        rand_ops();
        fixed_lat = 1;
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        wait_grant("bp");
        req_valid = '1;
        for (int i = 0; i < 50 && !rsp_valid; i++) step();
        repeat (5) step();
        rsp_ready = 1'b1;
        wait_grant("bp_next");
        req_valid = '0;
        wait_idle("bp");

        // Randomized traffic
        fixed_lat = -1;
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("random");

        // Reset three cycles into RUN
        rand_ops();
        fixed_lat = 10;
        req_valid = 4'b0100;
        wait_grant("rst_run");
        req_valid = '0;
        for (int i = 0; i < 20 && cyc < run_lo + 2; i++) step();
        reset = 1'b1;
        req_valid = '1;
        step();
        step();
        reset = 1'b0;
        fixed_lat = 1;
        n0 = dut_grants.size();
        wait_grant("post_reset");
        req_valid = '0;
        chk("post_reset_grant_seen", dut_grants.size() > n0, 1'b1);
        if (dut_grants.size() > n0) chk("post_reset_grant", dut_grants[n0], 0);
        wait_idle("post_reset");

        // Spurious done outside RUN
        spur = 1'b1;
        fixed_lat = 3;
        rand_ops();
        req_valid = 4'b1000;
        wait_grant("spur");
        req_valid = '0;
        wait_idle("spur");
        spur = 1'b0;

        // Core never finishes
        no_done = 1'b1;
        rand_ops();
        req_valid = 4'b0010;
        wait_grant("nodone");
        req_valid = '0;
`ifdef RSA_ARB_TIMEOUT_EN
        wait_idle("timeout");
`else
        repeat (110) step();
        chk("hang_busy", busy, 1'b1);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
`endif
        no_done = 1'b0;
        repeat (4) step();
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rsa_arbiter.md
# rsa_arbiter

Round-robin scheduler that shares one `RSA` modular-exponentiation core among `NREQ` requesters. It accepts one request at a time over per-requester valid/ready handshakes and latches that request's operands. It then sequences the core through its synchronous reset and returns the result, tagged with the requester ID, over a single valid/ready response channel. The block sits between the requester ports and the core's `Data`/`Key`/`N`/`reset`/`Result`/`Done` pins.

## Interface
- `WIDTH`, 6: operand/result width; matches the core's `WIDTH`.
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 255: RUN-cycle limit; used only with `RSA_ARB_TIMEOUT_EN`.
- Derived: `IDW` = max(1, ceil(log2 NREQ)).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  one-hot accept; transfer when `req_valid[i] & req_ready[i]`.
- `req_data`  in  NREQ*WIDTH  packed plaintext; requester i at bits [i*WIDTH +: WIDTH].
- `req_key`  in  NREQ*6  packed exponents; requester i at bits [i*6 +: 6].
- `req_n`  in  NREQ*WIDTH  packed moduli.
- `core_reset`  out  1  drives the core's `reset`.
- `core_data`, `core_n`  out  WIDTH each  latched operands to the core.
- `core_key`  out  6  latched exponent to the core.
- `core_result`  in  WIDTH  core `Result`.
- `core_done`  in  1  core `Done`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_id`  out  IDW  index of the served requester.
- `rsp_error`  out  1  timeout flag; constant 0 without the macro.
- `busy`  out  1  high when state != IDLE.

## Operation
- FSM states: IDLE, LAUNCH, RUN, RESP. Only one request is outstanding at a time.
- **IDLE.** If any `req_valid` bit is set, the grant `g` is the first set bit searching `ptr`, `ptr+1`, … modulo NREQ.
  - `req_ready[g]` is asserted combinationally in the same cycle.
  - On that edge: latch `req_data`/`req_key`/`req_n` slice g into `core_*`, store `g` as the ID, set `ptr <= (g+1) mod NREQ`, go to LAUNCH.
  - `req_ready` is 0 in every other state.
- **LAUNCH.** Exactly one cycle. New operands are presented while the core is held in reset. Next state is RUN.
- **RUN.** `core_reset` is 0.
  - On the first RUN cycle with `core_done`=1: capture `core_result` into `rsp_result`, set `rsp_error`=0, go to RESP.
- **RESP.** `rsp_valid`=1, and `rsp_result`/`rsp_id`/`rsp_error` are held stable.
  - On `rsp_valid & rsp_ready`, go to IDLE.
  - A new request can be granted no earlier than the following cycle.
- **Core reset.** `core_reset = reset | (state != RUN)`, so the core is quiescent outside RUN.
- **`core_done`** is ignored in IDLE, LAUNCH and RESP.
- **Key = 0.** The arbiter only waits for `core_done`; without the timeout macro, a core that never asserts done hangs the arbiter until `reset`.
- **Reset mid-operation.** Any state returns to IDLE, the in-flight request is dropped with no response, and `ptr` returns to 0.
- **Reset values:**
  - `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0, `rsp_error`=0, `busy`=0.
  - `core_data`/`core_key`/`core_n`=0, `core_reset`=1, `ptr`=0, state IDLE.
  - After reset, requester 0 has the highest priority.

## Timing
- Request accepted at edge T (IDLE). LAUNCH occupies T+1; RUN begins at T+2, the first cycle with `core_reset`=0.
- If `core_done` is first seen in RUN cycle D, `rsp_valid` is high from D+1.
- Response latency is (core run time) + 2 cycles.
- Minimum spacing between grants is 4 cycles: IDLE, LAUNCH, RUN, RESP with immediate `rsp_ready`.
- `rsp_*` changes only on entry to RESP. Outputs are registered except `req_ready` and `core_reset`, which are decoded from state.

## Configuration
- Macro: `RSA_ARB_TIMEOUT_EN`.
- **Defined.** A counter clears on entering RUN and increments each RUN cycle.
  - If `TIMEOUT` RUN cycles elapse without `core_done`, go to RESP with `rsp_error`=1 and `rsp_result`=0.
  - A `core_done` in the TIMEOUTth cycle wins, giving a normal response.
- **Undefined.** No counter is built; `rsp_error` is tied to 0 and RUN waits indefinitely.

## Test plan
- **Single request.** Requester 1 sends data=2, key=3, n=5 against the core model. Required: `req_ready[1]` at T, `core_reset` low from T+2, and `rsp_valid` with `rsp_result`=3 and `rsp_id`=1 one cycle after `core_done`.
- **Fairness.** All four `req_valid` held from reset with `rsp_ready`=1. Required: grants in order 0,1,2,3,0, and never two `req_ready` bits high at once.
- **Backpressure.** `rsp_ready` held low for 5 cycles in RESP. Required: `rsp_valid`/`rsp_result`/`rsp_id` stable, `req_ready`=0 and `busy`=1 throughout; IDLE is reached the cycle after `rsp_ready` rises.
- **Reset in RUN.** Assert `reset` 3 cycles into RUN. Required: no `rsp_valid`, `core_reset`=1, and the next grant with all requests valid goes to requester 0.
- **Spurious done.** `core_done`=1 during LAUNCH only. Required: it is ignored and the result is captured only on a done seen in RUN.
- **Timeout.** With `RSA_ARB_TIMEOUT_EN` defined, `TIMEOUT`=8 and `core_done` held 0. Required: `rsp_valid` with `rsp_error`=1 and `rsp_result`=0 the cycle after the 8th RUN cycle. Without the macro: `busy` stays 1 for more than 100 cycles.
